mmss_set_counter: RTL
=====================

// Module: mmss_set_counter
// PURPOSE
//  Settable MM:SS time base for the digital clock. Counts 1 Hz ticks into BCD
//  minutes/seconds (00:00-59:59), with two-button set mode (debounced).
//  Drives the display: {min_bcd, sec_bcd} feeds the 16-bit digit input of x7seg,
//  digit_blank drives per-digit blanking. Replaces the free-running counter+BCD pair.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   cycles a synced button must be stable to be accepted (10 ms @100 MHz)
//  BLINK_CYCLES     25_000_000  cycles per blink half-period in set states (0.25 s @100 MHz)
//  SYNC_STAGES      2           flip-flop synchronizer depth on each raw button
// PORTS
//  clk          in   1   system clock, 100 MHz
//  clr          in   1   synchronous, active-high reset
//  tick_1s      in   1   one-cycle pulse, once per second, synchronous to clk
//  btn_mode     in   1   raw asynchronous mode button, active-high, bouncy
//  btn_inc      in   1   raw asynchronous increment button, active-high, bouncy
//  min_bcd      out  8   minutes, {tens[3:0], ones[3:0]}, 00-59
//  sec_bcd      out  8   seconds, {tens[3:0], ones[3:0]}, 00-59
//  digit_blank  out  4   1 = blank digit; [3]=min tens .. [0]=sec ones
//  set_mode     out  2   00 RUN, 01 SET_MIN, 10 SET_SEC (11 never)
//  min_wrap     out  1   one-cycle pulse on 59:59->00:00 rollover in RUN
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high: when clr is high at a clk edge, the next state is:
//    min_bcd=sec_bcd=8'h00, digit_blank=4'b0000, set_mode=00, min_wrap=0,
//    synchronizers/debounced levels/debounce and blink counters = 0. clr has priority over everything.
//  - Button path (per button): SYNC_STAGES-flop sync -> debounce counter counts consecutive cycles
//    where synced != debounced level; counter clears when they match; at DEBOUNCE_CYCLES the level flips.
//    Press = registered one-cycle pulse the cycle after debounced level goes 0->1.
//    Raw edge at cycle 0, clean -> press high at cycle SYNC_STAGES+DEBOUNCE_CYCLES+1.
//    Exactly one press per accepted 0->1 transition; holding gives no repeat.
//  - A button held through reset yields one press after DEBOUNCE_CYCLES post-reset (level resets to 0).
//  - FSM: RUN -mode-> SET_MIN -mode-> SET_SEC -mode-> RUN. Transition takes effect next edge.
//  - RUN: tick_1s increments sec (BCD ones 9->0 carries to tens; 59->00 carries to min).
//    Min 59->00 on carry; at 59:59 tick -> 00:00 and min_wrap=1 that same update cycle. inc press ignored.
//  - SET_MIN: tick_1s ignored (time frozen). inc press: min+1 mod 60, sec unchanged, no min_wrap.
//  - SET_SEC: tick_1s ignored. inc press: sec+1 mod 60, no carry into min, no min_wrap.
//  - Counters are BCD registers driven straight to outputs (update on the same edge as the event).
//  - Simultaneous mode+inc press: mode wins, inc dropped.
//    tick_1s+mode in RUN: tick applied AND state -> SET_MIN.
//  - Blink: counter runs only in SET_*; phase toggles every BLINK_CYCLES cycles.
//    Phase 1 blanks 4'b1100 (SET_MIN) or 4'b0011 (SET_SEC); phase 0 and RUN -> 4'b0000.
//    Counter and phase clear to 0 on every state change and every accepted inc press
//    (digit visible immediately after edit).
//  - Leaving SET_SEC resumes counting from the edited value on the next tick_1s; no prescaler reset.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, SYNC_STAGES=2)
//  1. clr, then 61 tick_1s pulses -> min_bcd=8'h01, sec_bcd=8'h01, min_wrap never high, set_mode=00.
//  2. Set 59:59 via set mode, back to RUN, one tick -> 00:00, min_wrap high exactly 1 cycle.
//  3. SET_MIN, btn_inc toggling every 2 cycles for 20 cycles then held 10 -> min +1 exactly once;
//     raw clean edge -> press at cycle 7.
//  4. SET_SEC from 00:00, 60 inc presses with ticks running -> sec back to 00, min 00, no min_wrap.
//     mode -> RUN, next tick gives 00:01.
//  5. SET_MIN idle: digit_blank alternates 0000/1100 every 8 cycles; inc press -> 0000 next cycle, phase restarts.
//  6. mode+inc presses same cycle in SET_MIN -> SET_SEC, min unchanged.
//     clr during SET_SEC at 12:34 -> next cycle 00:00, set_mode 00, blank 0000.

Source files
------------

// File: rtl/mmss_set_counter.sv
// mmss_set_counter
//   Settable MM:SS time base for the digital clock. It counts 1 Hz ticks into
//   BCD minutes and seconds (00:00-59:59). Two debounced buttons set the time:
//   "mode" steps RUN -> SET_MIN -> SET_SEC -> RUN, and "inc" bumps the field
//   being edited. While a field is being edited it blinks on the display.
//
// Ports
//   clk          in   1  system clock
//   clr          in   1  synchronous active-high reset, highest priority
//   tick_1s      in   1  one-cycle pulse per second, synchronous to clk
//   btn_mode     in   1  raw asynchronous mode button, active-high, bouncy
//   btn_inc      in   1  raw asynchronous increment button, active-high, bouncy
//   min_bcd      out  8  minutes {tens, ones}, 00-59
//   sec_bcd      out  8  seconds {tens, ones}, 00-59
//   digit_blank  out  4  1 = blank digit; [3]=min tens .. [0]=sec ones
//   set_mode     out  2  00 RUN, 01 SET_MIN, 10 SET_SEC
//   min_wrap     out  1  one-cycle pulse on the 59:59 -> 00:00 rollover in RUN
module mmss_set_counter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [3:0] digit_blank,
  output logic [1:0] set_mode,
  output logic       min_wrap
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } mode_t;

  // Button index 0 is mode, index 1 is inc.
  logic [1:0]             btn_raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [DB_W-1:0]        db_cnt [2];
  logic [1:0]             db_level;
  logic [1:0]             level_d;
  logic [1:0]             press;
  logic                   mode_press;
  logic                   inc_press;

  mode_t                  state_q;
  mode_t                  state_d;

  logic [8:0]             sec_inc;
  logic [8:0]             min_inc;

  logic [BL_W-1:0]        blink_cnt;
  logic                   blink_phase;

  assign btn_raw    = {btn_inc, btn_mode};
  assign mode_press = press[0];
  assign inc_press  = press[1];

  // BCD increment modulo 60. Result is {carry, next}; carry is set only on 59 -> 00.
  function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
    logic [8:0] r;
    if (v[3:0] != 4'd9)
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = 9'h100;
    return r;
  endfunction

  // Synchronizer, debouncer and press detector for both buttons.
  // The debounced level only flips after the synced input has disagreed with
  // it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the run.
  // The press pulse is registered off the 0->1 change of the debounced level,
  // so a held button gives exactly one press.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int b = 0; b < 2; b++) begin
        sync_q[b] <= '0;
        db_cnt[b] <= '0;
      end
      db_level <= '0;
      level_d  <= '0;
      press    <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int s = SYNC_STAGES - 1; s > 0; s--) begin
          sync_q[b][s] <= sync_q[b][s-1];
        end
        sync_q[b][0] <= btn_raw[b];

        if (sync_q[b][SYNC_STAGES-1] == db_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db_cnt[b]   <= '0;
          db_level[b] <= ~db_level[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
      level_d <= db_level;
      press   <= db_level & ~level_d;
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode sequencing: each mode press advances one step around the ring.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    sec_inc = bcd60_inc(sec_bcd);
    min_inc = bcd60_inc(min_bcd);
  end

  // Time registers. In RUN a tick counts with carry into minutes, even on the
  // cycle a mode press moves us to SET_MIN. In the set states ticks are
  // ignored and an inc press edits one field without carry; a mode press in
  // the same cycle takes precedence and the inc is dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      min_wrap <= 1'b0;
    end else begin
      min_wrap <= 1'b0;
      case (state_q)
        RUN: begin
          if (tick_1s) begin
            sec_bcd <= sec_inc[7:0];
            if (sec_inc[8]) begin
              min_bcd  <= min_inc[7:0];
              min_wrap <= min_inc[8];
            end
          end
        end
        SET_MIN: begin
          if (inc_press && !mode_press) begin
            min_bcd <= min_inc[7:0];
          end
        end
        SET_SEC: begin
          if (inc_press && !mode_press) begin
            sec_bcd <= sec_inc[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Blink timer. It restarts on every mode change and every inc press so the
  // field being edited is visible right after a change, and stays idle in RUN.
  always_ff @(posedge clk) begin
    if (clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if ((state_d != state_q) || inc_press || (state_q == RUN)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end

  always_comb begin
    digit_blank = 4'b0000;
    if (blink_phase) begin
      case (state_q)
        SET_MIN: digit_blank = 4'b1100;
        SET_SEC: digit_blank = 4'b0011;
        default: digit_blank = 4'b0000;
      endcase
    end
  end

  assign set_mode = state_q;

endmodule
